elevator_scheduler: RTL

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// Four-floor elevator scheduler: latches floor calls, picks the next stop in the
// current sweep direction, retargets to closer calls en route and times the door.
module elevator_scheduler #(
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] call_req,
  input  logic [1:0] cur_floor,
  output logic [1:0] target_floor,
  output logic       stop,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       dir,
  output logic [3:0] serviced_count
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_pending;
  logic [1:0] r_target;
  logic       r_stop;
  logic       r_door;
  logic       r_dir;
  logic [3:0] r_count;
  logic [3:0] r_door_cnt;

  logic       w_up_found;
  logic [1:0] w_up_floor;
  logic       w_dn_found;
  logic [1:0] w_dn_floor;
  logic       w_clear_en;
  logic [3:0] w_pending_next;

  // Nearest pending floor strictly above / strictly below the car.
  always_comb begin
    w_up_found = 1'b0;
    w_up_floor = 2'd0;
    w_dn_found = 1'b0;
    w_dn_floor = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(cur_floor))) begin
        w_up_found = 1'b1;
        w_up_floor = 2'(i);
      end
    end
    for (int i = 0; i <= 3; i++) begin
      if (r_pending[i] && (i < int'(cur_floor))) begin
        w_dn_found = 1'b1;
        w_dn_floor = 2'(i);
      end
    end
  end

  // A stop is being made at cur_floor on this edge (from IDLE or on arrival).
  assign w_clear_en = ((r_state == S_IDLE) && r_pending[cur_floor]) ||
                      ((r_state == S_MOVE) && (cur_floor == r_target));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      logic w_here;
      logic w_set;
      assign w_here = (cur_floor == 2'(gi));
      assign w_set  = call_req[gi] && !((r_state == S_DOOR) && w_here);
      // Clearing takes priority over a same-cycle call for the serviced floor.
      assign w_pending_next[gi] = (w_clear_en && w_here) ? 1'b0 : (r_pending[gi] | w_set);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pending  <= 4'd0;
      r_target   <= 2'd0;
      r_stop     <= 1'b1;
      r_door     <= 1'b0;
      r_dir      <= 1'b1;
      r_count    <= 4'd0;
      r_door_cnt <= 4'd0;
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        S_IDLE: begin
          r_stop <= 1'b1;
          r_door <= 1'b0;
          if (r_pending[cur_floor]) begin
            r_state    <= S_DOOR;
            r_door     <= 1'b1;
            r_count    <= r_count + 4'd1;
            r_door_cnt <= DOOR_LOAD;
          end else if (r_pending != 4'd0) begin
            r_state <= S_MOVE;
            r_stop  <= 1'b0;
            if (r_dir ? w_up_found : w_dn_found) begin
              r_target <= r_dir ? w_up_floor : w_dn_floor;
            end else begin
              // Nothing ahead: reverse the sweep.
              r_dir    <= ~r_dir;
              r_target <= r_dir ? w_dn_floor : w_up_floor;
            end
          end
        end
        S_MOVE: begin
          if (cur_floor == r_target) begin
            r_state    <= S_DOOR;
            r_stop     <= 1'b1;
            r_door     <= 1'b1;
            r_count    <= r_count + 4'd1;
            r_door_cnt <= DOOR_LOAD;
          end else if (r_dir && w_up_found && (w_up_floor < r_target)) begin
            r_target <= w_up_floor;
          end else if (!r_dir && w_dn_found && (w_dn_floor > r_target)) begin
            r_target <= w_dn_floor;
          end
        end
        S_DOOR: begin
          if (r_door_cnt == 4'd0) begin
            r_state <= S_IDLE;
            r_door  <= 1'b0;
          end else begin
            r_door_cnt <= r_door_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign target_floor   = r_target;
  assign stop           = r_stop;
  assign door_open      = r_door;
  assign pending        = r_pending;
  assign dir            = r_dir;
  assign serviced_count = r_count;

endmodule
